ctrl_pkt_tx: RTL and testbench
==============================

// Module: ctrl_pkt_tx
// PURPOSE
//  Control-packet transmitter: turns one config write request into a complete VLAN/IPv4/UDP
//  control packet on a 512-bit AXI-Stream master, in the format the RMT pipeline's config path parses.
//  Sits upstream of rmt_wrapper's s_axis (host/loader side); the transmit end of the control-packet path.
// PARAMETERS
//  C_M_AXIS_DATA_WIDTH   512             stream width; fixed 512, other values unsupported
//  C_M_AXIS_TUSER_WIDTH  128             tuser width; driven all-zero
//  PAYLOAD_MAX_BYTES     64              max config payload bytes per packet
//  VLAN_TCI              16'h000f        VLAN tag control field
//  UDP_DST_PORT          16'hf1f2        control UDP destination port
// PORTS
//  clk              in   1     stream clock
//  areset           in   1     asynchronous active-high reset
//  req_valid        in   1     config request valid
//  req_ready        out  1     request accepted when valid&&ready
//  req_module_id    in   8     target stage/module id
//  req_resource_id  in   8     target table/resource id
//  req_index        in   8     entry index
//  req_len          in   7     payload bytes, 1..PAYLOAD_MAX_BYTES
//  req_data         in   512   payload, byte0 in [7:0]
//  m_axis_tdata     out  512   packet data, network byte0 in [7:0]
//  m_axis_tkeep     out  64    byte enables
//  m_axis_tuser     out  128   all zero
//  m_axis_tvalid    out  1     beat valid
//  m_axis_tready    in   1     downstream ready
//  m_axis_tlast     out  1     last beat
//  busy             out  1     packet in flight
// BEHAVIOUR
//  Reset: state IDLE, req_ready=1, m_axis_tvalid/tlast=0, tdata/tkeep=0, busy=0, seq=0.
//  FSM: IDLE -(req accept)-> CSUM -(2 cyc)-> BEAT0 -(tready, total>64)-> BEAT1 -(tready)-> IDLE;
//   BEAT0 with total<=64 returns to IDLE on tready. req_ready=1 only in IDLE; the request is latched on accept.
//  Layout, bytes 0..45: dst MAC 06:07:08:09:0a:0b, src MAC 00:01:02:03:04:05, TPID 0x8100, VLAN_TCI,
//   EtherType 0x0800, IPv4 (ver/IHL 0x45, TOS 0, id 0, DF flags 0x4000, TTL 0x40, proto 0x11,
//   src 0x01000000... fixed consts in pkg), UDP src 0x04d2, dst UDP_DST_PORT, UDP csum 0.
//  Ctrl header, bytes 46..49: {seq, module_id, resource_id, index}; payload starts at byte 50.
//  total = 50+req_len; IP total len = 32+req_len; UDP len = 12+req_len; 16-bit, big-endian on wire.
//  IP checksum: ones-complement sum of 10 header halfwords (csum field=0); end-around-carry fold in
//   CSUM cycle 1, invert in cycle 2. First tvalid is 3 cycles after request accept.
//  tkeep: single beat = (1<<total)-1; two beats: beat0 all-ones, beat1 = (1<<(total-64))-1.
//  AXIS: tdata/tkeep/tlast held stable while tvalid&&!tready; tvalid never drops before acceptance.
//  Bytes beyond req_len forced to 0 even though tkeep masks them.
//  req_len 0 or >PAYLOAD_MAX_BYTES: clamped to 1 / max.
//  areset mid-packet: tvalid drops immediately (async); the partial packet is abandoned, no tlast.
// CONFIGURATION
//  CTRL_PKT_SEQ_EN defined: byte 46 = 8-bit seq counter; increments on tlast handshake, wraps 255->0.
//  Undefined: byte 46 = 8'h00; no counter flops.
// STRUCTURE
//  ctrl_pkt_pkg: MAC/IP/UDP constants, byte offsets (HDR_BYTES=46, CTRL_HDR_BYTES=4), state enum,
//   header struct, function keep_mask(n).
//  Sub-module ctrl_pkt_csum: 2-stage IPv4 header checksum (sum+fold, invert); the rest stays in top.
// TESTING
//  1 len=4, data 0x04: one beat, tlast=1, tkeep=0x003f_ffff_ffff_ffff, IP len 0x0024, UDP len 0x0010.
//  2 len=20: beat0 tkeep all-ones, tlast=0; beat1 tkeep=0x3f, tlast=1, payload bytes 14..19 at lanes 0..5.
//  3 any packet: recomputed header halfword sum incl. csum folds to 0xffff; bytes beyond len are 0.
//  4 tready low for 5 cycles mid-BEAT0: outputs stable; req_ready=0 until final handshake.
//  5 areset during BEAT1: tvalid=0 same cycle; after release a new len=4 request emits clean packet.
//  6 CTRL_PKT_SEQ_EN: 257 packets -> byte46 0,1,...,255,0; without macro, byte46 always 0.

Source files
------------

// File: rtl/ctrl_pkt_pkg.sv
// Control-packet transmitter shared definitions: fixed Ethernet/VLAN/IPv4/UDP header
// constants, byte offsets, the FSM state type, the on-wire header layout and the
// tkeep mask helper.
package ctrl_pkt_pkg;

   localparam logic [47:0] DST_MAC      = 48'h06_07_08_09_0a_0b;
   localparam logic [47:0] SRC_MAC      = 48'h00_01_02_03_04_05;
   localparam logic [15:0] TPID         = 16'h8100;
   localparam logic [15:0] ETH_IPV4     = 16'h0800;
   localparam logic [7:0]  IP_VER_IHL   = 8'h45;
   localparam logic [7:0]  IP_TOS       = 8'h00;
   localparam logic [15:0] IP_ID        = 16'h0000;
   localparam logic [15:0] IP_FLAGS     = 16'h4000;
   localparam logic [7:0]  IP_TTL       = 8'h40;
   localparam logic [7:0]  IP_PROTO     = 8'h11;
   localparam logic [31:0] IP_SRC       = 32'h0100_0000;
   localparam logic [31:0] IP_DST       = 32'h0200_0000;
   localparam logic [15:0] UDP_SRC_PORT = 16'h04d2;
   localparam logic [15:0] UDP_CSUM     = 16'h0000;

   localparam int HDR_BYTES         = 46;
   localparam int CTRL_HDR_BYTES    = 4;
   localparam int PAYLOAD_OFS       = HDR_BYTES + CTRL_HDR_BYTES;
   localparam int HDR_BITS          = 8 * PAYLOAD_OFS;
   localparam int IP_LEN_BASE       = 32;
   localparam int UDP_LEN_BASE      = 12;
   localparam int BEAT_BYTES        = 64;
   localparam int IP_HDR_HALFWORDS  = 10;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_CSUM  = 2'd1,
      ST_BEAT0 = 2'd2,
      ST_BEAT1 = 2'd3
   } state_t;

   // Fields in wire order: the first field lands on network byte 0.
   typedef struct packed {
      logic [47:0] dst_mac;
      logic [47:0] src_mac;
      logic [15:0] tpid;
      logic [15:0] vlan_tci;
      logic [15:0] ethertype;
      logic [7:0]  ver_ihl;
      logic [7:0]  tos;
      logic [15:0] ip_len;
      logic [15:0] ip_id;
      logic [15:0] ip_flags;
      logic [7:0]  ttl;
      logic [7:0]  proto;
      logic [15:0] ip_csum;
      logic [31:0] ip_src;
      logic [31:0] ip_dst;
      logic [15:0] udp_src;
      logic [15:0] udp_dst;
      logic [15:0] udp_len;
      logic [15:0] udp_csum;
      logic [7:0]  seq;
      logic [7:0]  module_id;
      logic [7:0]  resource_id;
      logic [7:0]  index;
   } pkt_hdr_t;

   // Lower n byte lanes enabled; n >= 64 enables the whole beat.
   function automatic logic [63:0] keep_mask(input logic [7:0] n);
      if (n >= 8'd64) return '1;
      return (64'd1 << n) - 64'd1;
   endfunction

endpackage

// File: rtl/ctrl_pkt_csum.sv
// Two-stage IPv4 header checksum: stage 1 sums the ten header halfwords and folds the
// carries back in, stage 2 inverts. The input must hold the header with its checksum
// field zeroed and must stay stable for both stages.
module ctrl_pkt_csum
   import ctrl_pkt_pkg::*;
(
   input  logic         clk,
   input  logic         areset,
   input  logic [159:0] i_ip_hdr,
   output logic [15:0]  o_csum
);

   logic [19:0] w_sum;
   logic [16:0] w_fold1;
   logic [15:0] w_fold2;
   logic [15:0] r_fold;

   // Ones-complement sum with end-around carry; two folds cover a 20-bit sum.
   always_comb begin
      w_sum = '0;
      for (int i = 0; i < IP_HDR_HALFWORDS; i++) begin
         w_sum = w_sum + 20'(i_ip_hdr[16*i +: 16]);
      end
      w_fold1 = 17'(w_sum[15:0]) + 17'(w_sum[19:16]);
      w_fold2 = w_fold1[15:0] + 16'(w_fold1[16]);
   end

   // Stage 1 registers the folded sum, stage 2 the inverted checksum.
   always_ff @(posedge clk or posedge areset) begin
      if (areset) begin
         r_fold <= '0;
         o_csum <= '0;
      end else begin
         r_fold <= w_fold2;
         o_csum <= ~r_fold;
      end
   end

endmodule

// File: rtl/ctrl_pkt_tx.sv
// Control-packet transmitter: one config write request becomes one VLAN/IPv4/UDP control
// packet (one or two 512-bit beats) on an AXI-Stream master.
// Build option: define CTRL_PKT_SEQ_EN to place a wrapping 8-bit sequence counter in
// byte 46; without it byte 46 is constant zero.
//
// state    | meaning
// ST_IDLE  | req_ready high, waiting for a request
// ST_CSUM  | checksum fold, invert, then beat 0 registers load (3 cycles)
// ST_BEAT0 | first beat valid, held until tready
// ST_BEAT1 | second (last) beat valid, held until tready
module ctrl_pkt_tx
   import ctrl_pkt_pkg::*;
#(
   parameter int          C_M_AXIS_DATA_WIDTH  = 512,
   parameter int          C_M_AXIS_TUSER_WIDTH = 128,
   parameter int          PAYLOAD_MAX_BYTES    = 64,
   parameter logic [15:0] VLAN_TCI             = 16'h000f,
   parameter logic [15:0] UDP_DST_PORT         = 16'hf1f2
) (
   input  logic                              clk,
   input  logic                              areset,
   input  logic                              req_valid,
   output logic                              req_ready,
   input  logic [7:0]                        req_module_id,
   input  logic [7:0]                        req_resource_id,
   input  logic [7:0]                        req_index,
   input  logic [6:0]                        req_len,
   input  logic [C_M_AXIS_DATA_WIDTH-1:0]    req_data,
   output logic [C_M_AXIS_DATA_WIDTH-1:0]    m_axis_tdata,
   output logic [C_M_AXIS_DATA_WIDTH/8-1:0]  m_axis_tkeep,
   output logic [C_M_AXIS_TUSER_WIDTH-1:0]   m_axis_tuser,
   output logic                              m_axis_tvalid,
   input  logic                              m_axis_tready,
   output logic                              m_axis_tlast,
   output logic                              busy
);

   state_t       r_state;
   logic [1:0]   r_cnt;
   logic [7:0]   r_module_id;
   logic [7:0]   r_resource_id;
   logic [7:0]   r_index;
   logic [6:0]   r_len;
   logic [511:0] r_data;
   logic [511:0] r_tdata;
   logic [63:0]  r_tkeep;
   logic         r_tvalid;
   logic         r_tlast;
   logic         r_req_ready;
   logic         r_busy;

   logic [6:0]    w_len_clamped;
   logic [63:0]   w_req_keep;
   logic [511:0]  w_req_data_masked;
   logic [7:0]    w_total;
   logic          w_two_beats;
   logic [15:0]   w_ip_len;
   logic [15:0]   w_udp_len;
   logic [159:0]  w_ip_hdr;
   logic [15:0]   w_csum;
   logic [7:0]    w_seq;
   pkt_hdr_t      w_hdr;
   logic [1023:0] w_pkt;

   assign w_len_clamped = (req_len == 7'd0) ? 7'd1 :
                          (req_len > 7'(PAYLOAD_MAX_BYTES)) ? 7'(PAYLOAD_MAX_BYTES) : req_len;

   // Payload lanes past the requested length are zeroed before latching.
   always_comb begin
      w_req_keep = keep_mask({1'b0, w_len_clamped});
      for (int i = 0; i < 64; i++) begin
         w_req_data_masked[8*i +: 8] = req_data[8*i +: 8] & {8{w_req_keep[i]}};
      end
   end

   assign w_total     = 8'(PAYLOAD_OFS) + {1'b0, r_len};
   assign w_two_beats = (w_total > 8'(BEAT_BYTES));
   assign w_ip_len    = 16'(IP_LEN_BASE) + {9'd0, r_len};
   assign w_udp_len   = 16'(UDP_LEN_BASE) + {9'd0, r_len};
   assign w_ip_hdr    = {IP_VER_IHL, IP_TOS, w_ip_len, IP_ID, IP_FLAGS,
                         IP_TTL, IP_PROTO, 16'h0000, IP_SRC, IP_DST};

   ctrl_pkt_csum u_csum (
      .clk      (clk),
      .areset   (areset),
      .i_ip_hdr (w_ip_hdr),
      .o_csum   (w_csum)
   );

`ifdef CTRL_PKT_SEQ_EN
   logic [7:0] r_seq;

   // Sequence number advances once per completed packet.
   always_ff @(posedge clk or posedge areset) begin
      if (areset) begin
         r_seq <= '0;
      end else if (r_tvalid && m_axis_tready && r_tlast) begin
         r_seq <= r_seq + 8'd1;
      end
   end

   assign w_seq = r_seq;
`else
   assign w_seq = 8'h00;
`endif

   // Header fields from the latched request and the finished checksum.
   always_comb begin
      w_hdr.dst_mac     = DST_MAC;
      w_hdr.src_mac     = SRC_MAC;
      w_hdr.tpid        = TPID;
      w_hdr.vlan_tci    = VLAN_TCI;
      w_hdr.ethertype   = ETH_IPV4;
      w_hdr.ver_ihl     = IP_VER_IHL;
      w_hdr.tos         = IP_TOS;
      w_hdr.ip_len      = w_ip_len;
      w_hdr.ip_id       = IP_ID;
      w_hdr.ip_flags    = IP_FLAGS;
      w_hdr.ttl         = IP_TTL;
      w_hdr.proto       = IP_PROTO;
      w_hdr.ip_csum     = w_csum;
      w_hdr.ip_src      = IP_SRC;
      w_hdr.ip_dst      = IP_DST;
      w_hdr.udp_src     = UDP_SRC_PORT;
      w_hdr.udp_dst     = UDP_DST_PORT;
      w_hdr.udp_len     = w_udp_len;
      w_hdr.udp_csum    = UDP_CSUM;
      w_hdr.seq         = w_seq;
      w_hdr.module_id   = r_module_id;
      w_hdr.resource_id = r_resource_id;
      w_hdr.index       = r_index;
   end

   // Whole packet as a byte-lane vector: network byte i at [8i+7:8i].
   always_comb begin
      w_pkt = '0;
      for (int i = 0; i < PAYLOAD_OFS; i++) begin
         w_pkt[8*i +: 8] = w_hdr[HDR_BITS-1-8*i -: 8];
      end
      w_pkt[HDR_BITS +: 512] = r_data;
   end

   // Request latch, sequencing and registered stream outputs.
   always_ff @(posedge clk or posedge areset) begin
      if (areset) begin
         r_state       <= ST_IDLE;
         r_cnt         <= '0;
         r_module_id   <= '0;
         r_resource_id <= '0;
         r_index       <= '0;
         r_len         <= 7'd1;
         r_data        <= '0;
         r_tdata       <= '0;
         r_tkeep       <= '0;
         r_tvalid      <= 1'b0;
         r_tlast       <= 1'b0;
         r_req_ready   <= 1'b1;
         r_busy        <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (req_valid) begin
                  r_module_id   <= req_module_id;
                  r_resource_id <= req_resource_id;
                  r_index       <= req_index;
                  r_len         <= w_len_clamped;
                  r_data        <= w_req_data_masked;
                  r_cnt         <= '0;
                  r_req_ready   <= 1'b0;
                  r_busy        <= 1'b1;
                  r_state       <= ST_CSUM;
               end
            end
            ST_CSUM: begin
               if (r_cnt == 2'd2) begin
                  r_tdata  <= w_pkt[511:0];
                  r_tkeep  <= w_two_beats ? '1 : keep_mask(w_total);
                  r_tlast  <= !w_two_beats;
                  r_tvalid <= 1'b1;
                  r_state  <= ST_BEAT0;
               end else begin
                  r_cnt <= r_cnt + 2'd1;
               end
            end
            ST_BEAT0: begin
               if (m_axis_tready) begin
                  if (w_two_beats) begin
                     r_tdata <= w_pkt[1023:512];
                     r_tkeep <= keep_mask(w_total - 8'(BEAT_BYTES));
                     r_tlast <= 1'b1;
                     r_state <= ST_BEAT1;
                  end else begin
                     r_tdata     <= '0;
                     r_tkeep     <= '0;
                     r_tvalid    <= 1'b0;
                     r_tlast     <= 1'b0;
                     r_req_ready <= 1'b1;
                     r_busy      <= 1'b0;
                     r_state     <= ST_IDLE;
                  end
               end
            end
            ST_BEAT1: begin
               if (m_axis_tready) begin
                  r_tdata     <= '0;
                  r_tkeep     <= '0;
                  r_tvalid    <= 1'b0;
                  r_tlast     <= 1'b0;
                  r_req_ready <= 1'b1;
                  r_busy      <= 1'b0;
                  r_state     <= ST_IDLE;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign req_ready     = r_req_ready;
   assign busy          = r_busy;
   assign m_axis_tdata  = r_tdata;
   assign m_axis_tkeep  = r_tkeep;
   assign m_axis_tvalid = r_tvalid;
   assign m_axis_tlast  = r_tlast;
   assign m_axis_tuser  = '0;

endmodule

// File: tb/tb_ctrl_pkt_tx.sv
// Directed bench for ctrl_pkt_tx with a beat scoreboard built from an independent
// byte-level packet model.
module tb_ctrl_pkt_tx;

   logic         clk = 1'b0;
   logic         areset;
   logic         req_valid;
   logic         req_ready;
   logic [7:0]   req_module_id;
   logic [7:0]   req_resource_id;
   logic [7:0]   req_index;
   logic [6:0]   req_len;
   logic [511:0] req_data;
   logic [511:0] m_axis_tdata;
   logic [63:0]  m_axis_tkeep;
   logic [127:0] m_axis_tuser;
   logic         m_axis_tvalid;
   logic         m_axis_tready;
   logic         m_axis_tlast;
   logic         busy;

   typedef struct {
      logic [511:0] d;
      logic [63:0]  k;
      logic         l;
   } beat_t;

   beat_t       sb_q[$];
   logic [7:0]  exp_b [0:127];
   logic [7:0]  exp_seq;
   int          n_pass;
   int          n_fail;
   int          n_total;
   int          g_guard;
   beat_t       g_bt;

   ctrl_pkt_tx dut (
      .clk             (clk),
      .areset          (areset),
      .req_valid       (req_valid),
      .req_ready       (req_ready),
      .req_module_id   (req_module_id),
      .req_resource_id (req_resource_id),
      .req_index       (req_index),
      .req_len         (req_len),
      .req_data        (req_data),
      .m_axis_tdata    (m_axis_tdata),
      .m_axis_tkeep    (m_axis_tkeep),
      .m_axis_tuser    (m_axis_tuser),
      .m_axis_tvalid   (m_axis_tvalid),
      .m_axis_tready   (m_axis_tready),
      .m_axis_tlast    (m_axis_tlast),
      .busy            (busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [511:0] rnd512();
      logic [511:0] d;
      for (int i = 0; i < 16; i++) d[32*i +: 32] = $urandom;
      return d;
   endfunction

   // Folded ones-complement sum of the observed IPv4 header, checksum included.
   function automatic logic [15:0] hdr_fold(input logic [511:0] d);
      int unsigned s;
      s = 0;
      for (int i = 18; i < 38; i += 2) s += {16'h0, d[8*i +: 8], d[8*(i+1) +: 8]};
      while ((s >> 16) != 0) s = (s & 32'h0000_ffff) + (s >> 16);
      return 16'(s);
   endfunction

   task automatic push_pkt(input logic [7:0] seq, input logic [7:0] mod, input logic [7:0] res,
                           input logic [7:0] idx, input int len_raw, input logic [511:0] data);
      int          len;
      int          total;
      int unsigned s;
      beat_t       bt;
      len   = (len_raw == 0) ? 1 : (len_raw > 64) ? 64 : len_raw;
      total = 50 + len;
      for (int i = 0; i < 128; i++) exp_b[i] = 8'h00;
      for (int i = 0; i < 6; i++) begin
         exp_b[i]     = 8'(6 + i);
         exp_b[6 + i] = 8'(i);
      end
      exp_b[12] = 8'h81; exp_b[13] = 8'h00; exp_b[14] = 8'h00; exp_b[15] = 8'h0f;
      exp_b[16] = 8'h08; exp_b[17] = 8'h00; exp_b[18] = 8'h45; exp_b[19] = 8'h00;
      exp_b[20] = 8'((32 + len) >> 8); exp_b[21] = 8'(32 + len);
      exp_b[24] = 8'h40; exp_b[26] = 8'h40; exp_b[27] = 8'h11;
      exp_b[30] = 8'h01; exp_b[34] = 8'h02;
      exp_b[38] = 8'h04; exp_b[39] = 8'hd2; exp_b[40] = 8'hf1; exp_b[41] = 8'hf2;
      exp_b[42] = 8'((12 + len) >> 8); exp_b[43] = 8'(12 + len);
      exp_b[46] = seq; exp_b[47] = mod; exp_b[48] = res; exp_b[49] = idx;
      s = 0;
      for (int i = 18; i < 38; i += 2) s += {16'h0, exp_b[i], exp_b[i+1]};
      while ((s >> 16) != 0) s = (s & 32'h0000_ffff) + (s >> 16);
      s = ~s;
      exp_b[28] = 8'(s >> 8);
      exp_b[29] = 8'(s);
      for (int i = 0; i < len; i++) exp_b[50 + i] = data[8*i +: 8];
      for (int b = 0; b < ((total > 64) ? 2 : 1); b++) begin
         bt.d = '0;
         bt.k = '0;
         for (int i = 0; i < 64; i++) begin
            bt.d[8*i +: 8] = exp_b[64*b + i];
            bt.k[i]        = (64*b + i < total);
         end
         bt.l = (b == 1) || (total <= 64);
         sb_q.push_back(bt);
      end
   endtask

   task automatic send_req(input logic [7:0] mod, input logic [7:0] res, input logic [7:0] idx,
                           input logic [6:0] len, input logic [511:0] data);
      @(negedge clk);
      chk("req_ready_idle", 512'(req_ready), 512'(1));
      req_valid       = 1'b1;
      req_module_id   = mod;
      req_resource_id = res;
      req_index       = idx;
      req_len         = len;
      req_data        = data;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      chk("req_ready_after_accept", 512'(req_ready), 512'(0));
      chk("busy_after_accept", 512'(busy), 512'(1));
      push_pkt(exp_seq, mod, res, idx, int'(len), data);
   endtask

   task automatic collect(input int stall);
      int  lat;
      int  guard;
      bit  done;
      bit  first;
      beat_t bt;
      lat = 0; guard = 0; done = 1'b0; first = 1'b1;
      while (guard < 20) begin
         @(negedge clk);
         if (m_axis_tvalid) break;
         @(posedge clk);
         lat++;
         guard++;
      end
      chk("first_tvalid_latency", 512'(lat), 512'(3));
      if (stall > 0 && sb_q.size() > 0) begin
         m_axis_tready = 1'b0;
         repeat (stall) begin
            @(posedge clk);
            @(negedge clk);
            chk("stall_tvalid", 512'(m_axis_tvalid), 512'(1));
            chk("stall_tdata", m_axis_tdata, sb_q[0].d);
            chk("stall_tkeep", 512'(m_axis_tkeep), 512'(sb_q[0].k));
            chk("stall_tlast", 512'(m_axis_tlast), 512'(sb_q[0].l));
            chk("stall_req_ready", 512'(req_ready), 512'(0));
         end
         m_axis_tready = 1'b1;
      end
      guard = 0;
      while (!done && guard < 40) begin
         if (m_axis_tvalid && m_axis_tready) begin
            if (sb_q.size() == 0) begin
               chk("scoreboard_empty_on_beat", 512'(0), 512'(1));
               done = 1'b1;
            end else begin
               bt = sb_q.pop_front();
               chk("beat_tdata", m_axis_tdata, bt.d);
               chk("beat_tkeep", 512'(m_axis_tkeep), 512'(bt.k));
               chk("beat_tlast", 512'(m_axis_tlast), 512'(bt.l));
               chk("beat_tuser", 512'(m_axis_tuser), 512'(0));
               chk("beat_busy", 512'(busy), 512'(1));
               chk("beat_req_ready", 512'(req_ready), 512'(0));
               if (first) chk("ip_csum_fold", 512'(hdr_fold(m_axis_tdata)), 512'(16'hffff));
               first = 1'b0;
               if (bt.l) done = 1'b1;
            end
         end
         @(posedge clk);
         @(negedge clk);
         guard++;
      end
      chk("packet_completed", 512'(done), 512'(1));
      chk("post_tvalid", 512'(m_axis_tvalid), 512'(0));
      chk("post_req_ready", 512'(req_ready), 512'(1));
      chk("post_busy", 512'(busy), 512'(0));
`ifdef CTRL_PKT_SEQ_EN
      exp_seq = exp_seq + 8'd1;
`endif
   endtask

   initial begin
      n_pass = 0; n_fail = 0; n_total = 0;
      exp_seq = 8'h00;
      areset = 1'b1;
      req_valid = 1'b0; req_module_id = '0; req_resource_id = '0; req_index = '0;
      req_len = '0; req_data = '0;
      m_axis_tready = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_req_ready", 512'(req_ready), 512'(1));
      chk("rst_tvalid", 512'(m_axis_tvalid), 512'(0));
      chk("rst_tlast", 512'(m_axis_tlast), 512'(0));
      chk("rst_tdata", m_axis_tdata, 512'(0));
      chk("rst_tkeep", 512'(m_axis_tkeep), 512'(0));
      chk("rst_busy", 512'(busy), 512'(0));
      areset = 1'b0;

      // Single beat, len 4, payload bytes 0x04.
      send_req(8'h01, 8'h02, 8'h03, 7'd4, {64{8'h04}});
      chk("len4_tkeep_const", 512'(sb_q[0].k), 512'(64'h003f_ffff_ffff_ffff));
      collect(0);

      // Two beats, len 20, random payload with garbage beyond len.
      send_req(8'h0a, 8'h0b, 8'h0c, 7'd20, rnd512());
      chk("len20_beat1_tkeep_const", 512'(sb_q[1].k), 512'(64'h3f));
      collect(0);

      // Backpressure for 5 cycles on beat 0.
      send_req(8'h21, 8'h22, 8'h23, 7'd30, rnd512());
      collect(5);

      // Backpressure on a single-beat packet.
      send_req(8'h31, 8'h32, 8'h33, 7'd14, rnd512());
      collect(3);

      // Boundary lengths: 0 clamps to 1, 100 clamps to 64, exact 64, and 15 (first two-beat).
      send_req(8'h41, 8'h42, 8'h43, 7'd0, rnd512());
      collect(0);
      send_req(8'h51, 8'h52, 8'h53, 7'd100, rnd512());
      collect(0);
      send_req(8'h61, 8'h62, 8'h63, 7'd64, rnd512());
      collect(0);
      send_req(8'h71, 8'h72, 8'h73, 7'd15, rnd512());
      collect(0);

      // Reset while the second beat is pending.
      m_axis_tready = 1'b0;
      send_req(8'h11, 8'h22, 8'h33, 7'd20, rnd512());
      g_guard = 0;
      while (g_guard < 20) begin
         @(negedge clk);
         if (m_axis_tvalid) break;
         @(posedge clk);
         g_guard++;
      end
      chk("rst_test_beat0_valid", 512'(m_axis_tvalid), 512'(1));
      if (sb_q.size() > 0) begin
         g_bt = sb_q.pop_front();
         chk("rst_test_beat0_tdata", m_axis_tdata, g_bt.d);
      end
      m_axis_tready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      m_axis_tready = 1'b0;
      chk("rst_test_beat1_valid", 512'(m_axis_tvalid), 512'(1));
      chk("rst_test_beat1_tlast", 512'(m_axis_tlast), 512'(1));
      #2 areset = 1'b1;
      #1;
      chk("areset_tvalid_drop", 512'(m_axis_tvalid), 512'(0));
      chk("areset_tlast_drop", 512'(m_axis_tlast), 512'(0));
      chk("areset_req_ready", 512'(req_ready), 512'(1));
      chk("areset_busy", 512'(busy), 512'(0));
      sb_q.delete();
      exp_seq = 8'h00;
      @(negedge clk);
      areset = 1'b0;
      m_axis_tready = 1'b1;
      send_req(8'h01, 8'h02, 8'h03, 7'd4, rnd512());
      collect(0);

`ifdef CTRL_PKT_SEQ_EN
      // Sequence byte wraps 255 -> 0 across 257 packets after reset.
      areset = 1'b1;
      @(negedge clk);
      areset = 1'b0;
      exp_seq = 8'h00;
      for (int k = 0; k < 257; k++) begin
         send_req(8'(k), 8'h5a, 8'ha5, 7'd4, rnd512());
         collect(0);
      end
`endif

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
